// File: rtl/fetch_queue.sv
// Instruction fetch stage: generates the PC, issues word reads to instruction memory and
// buffers returned instructions with their PCs in a DEPTH-entry FIFO drained by decode.
module fetch_queue #(
  parameter int unsigned           ADDR_WIDTH = 32,
  parameter int unsigned           DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = 32'h80020000,
  parameter int unsigned           DEPTH      = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     srec_parse,
  input  logic                     redirect_valid_in,
  input  logic [ADDR_WIDTH-1:0]    redirect_pc_in,
  input  logic [DATA_WIDTH-1:0]    mem_data_in,
  output logic                     mem_req_out,
  output logic [ADDR_WIDTH-1:0]    mem_addr_out,
  output logic                     mem_rw_out,
  output logic [1:0]               mem_access_size_out,
  input  logic                     insn_ready_in,
  output logic                     insn_valid_out,
  output logic [DATA_WIDTH-1:0]    insn_out,
  output logic [ADDR_WIDTH-1:0]    insn_pc_out,
  output logic [$clog2(DEPTH):0]   fifo_count_out
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  typedef enum logic {LOAD, RUN} state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] pc;
  logic                  inflight;
  logic [ADDR_WIDTH-1:0] inflight_pc;
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [CW-1:0]         count;
  logic [DATA_WIDTH-1:0] data_q [DEPTH];
  logic [ADDR_WIDTH-1:0] pc_q   [DEPTH];

  logic                  run;
  logic                  flush;
  logic                  issue;
  logic                  push;
  logic                  pop;
  logic [CW:0]           credit_used;

  // srec_parse gates fetch combinationally so the hold takes effect in the cycle it rises.
  assign run         = (state == RUN) && !srec_parse;
  assign flush       = !run || redirect_valid_in;
  assign credit_used = {1'b0, count} + {{CW{1'b0}}, inflight};
  assign issue       = !rst && run && !redirect_valid_in && (credit_used < (CW+1)'(DEPTH));
  assign push        = inflight && !flush;
  assign pop         = (count != '0) && insn_ready_in && !flush;

  assign mem_req_out         = issue;
  assign mem_addr_out        = pc;
  assign mem_rw_out          = 1'b0;
  assign mem_access_size_out = 2'b10;
  assign insn_valid_out      = (count != '0);
  assign insn_out            = data_q[rd_ptr];
  assign insn_pc_out         = pc_q[rd_ptr];
  assign fifo_count_out      = count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= RUN;
      pc          <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        data_q[i] <= '0;
        pc_q[i]   <= '0;
      end
    end else begin
      state    <= srec_parse ? LOAD : RUN;
      inflight <= issue;
      if (issue) begin
        inflight_pc <= pc;
      end

      if (!run) begin
        pc <= RESET_PC;
      end else if (redirect_valid_in) begin
        pc <= {redirect_pc_in[ADDR_WIDTH-1:2], 2'b00};
      end else if (issue) begin
        pc <= pc + ADDR_WIDTH'(4);
      end

      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) begin
          data_q[wr_ptr] <= mem_data_in;
          pc_q[wr_ptr]   <= inflight_pc;
          wr_ptr         <= wr_ptr + PW'(1);
        end
        if (pop) begin
          rd_ptr <= rd_ptr + PW'(1);
        end
        case ({push, pop})
          2'b10:   count <= count + CW'(1);
          2'b01:   count <= count - CW'(1);
          default: count <= count;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: streaming, back-pressure, redirect, SREC hold, async reset
// and PC wrap (second instance with an overridden reset PC).
module tb_fetch_queue;

  localparam logic [31:0] RPC  = 32'h80020000;
  localparam logic [31:0] WPC  = 32'hFFFFFFFC;
  localparam logic [31:0] DKEY = 32'hC3C30000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        srec_parse = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic [31:0] mem_data = '0;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_rw;
  logic [1:0]  mem_size;
  logic        ready = 1'b1;
  logic        valid;
  logic [31:0] insn;
  logic [31:0] insn_pc;
  logic [2:0]  count;

  logic [31:0] w_data = '0;
  logic        w_req;
  logic [31:0] w_addr;
  logic        w_rw;
  logic [1:0]  w_size;
  logic        w_valid;
  logic [31:0] w_insn;
  logic [31:0] w_insn_pc;
  logic [2:0]  w_count;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  // Memory model: data is a fixed function of the requested address, one cycle later.
  always @(posedge clk) begin
    mem_data <= mem_addr ^ DKEY;
    w_data   <= w_addr ^ DKEY;
  end

  fetch_queue #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .RESET_PC(RPC), .DEPTH(4)) dut (
    .clk(clk), .rst(rst), .srec_parse(srec_parse),
    .redirect_valid_in(redirect_valid), .redirect_pc_in(redirect_pc),
    .mem_data_in(mem_data), .mem_req_out(mem_req), .mem_addr_out(mem_addr),
    .mem_rw_out(mem_rw), .mem_access_size_out(mem_size),
    .insn_ready_in(ready), .insn_valid_out(valid), .insn_out(insn),
    .insn_pc_out(insn_pc), .fifo_count_out(count)
  );

  fetch_queue #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .RESET_PC(WPC), .DEPTH(4)) dut_wrap (
    .clk(clk), .rst(rst), .srec_parse(1'b0),
    .redirect_valid_in(1'b0), .redirect_pc_in(32'h0),
    .mem_data_in(w_data), .mem_req_out(w_req), .mem_addr_out(w_addr),
    .mem_rw_out(w_rw), .mem_access_size_out(w_size),
    .insn_ready_in(1'b1), .insn_valid_out(w_valid), .insn_out(w_insn),
    .insn_pc_out(w_insn_pc), .fifo_count_out(w_count)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " req"},   32'(mem_req),  32'd0);
    check({tag, " addr"},  mem_addr,      RPC);
    check({tag, " rw"},    32'(mem_rw),   32'd0);
    check({tag, " size"},  32'(mem_size), 32'd2);
    check({tag, " valid"}, 32'(valid),    32'd0);
    check({tag, " insn"},  insn,          32'd0);
    check({tag, " pc"},    insn_pc,       32'd0);
    check({tag, " count"}, 32'(count),    32'd0);
  endtask

  initial begin
    int n;
    int got;
    logic [31:0] exp;

    // Reset values and streaming with ready held high.
    rst = 1'b1; ready = 1'b1;
    step(); step(); #1;
    check_reset_outputs("rst");
    check("wrap rst addr", w_addr, WPC);
    rst = 1'b0; #1;
    check("c0 req", 32'(mem_req), 32'd1);
    check("c0 addr", mem_addr, RPC);
    check("wrap c0 addr", w_addr, WPC);
    step(); #1;
    check("c1 addr", mem_addr, RPC + 32'd4);
    check("c1 valid", 32'(valid), 32'd0);
    check("wrap c1 addr", w_addr, 32'h0);
    for (int k = 0; k < 6; k++) begin
      step(); #1;
      check("stream valid", 32'(valid), 32'd1);
      check("stream pc", insn_pc, RPC + 32'(4 * k));
      check("stream insn", insn, (RPC + 32'(4 * k)) ^ DKEY);
      check("stream addr", mem_addr, RPC + 32'(4 * (k + 2)));
      if (k == 0) check("wrap pc0", w_insn_pc, WPC);
      if (k == 1) check("wrap pc1", w_insn_pc, 32'h0);
    end

    // Back-pressure: exactly DEPTH requests, then drain in order.
    rst = 1'b1; ready = 1'b0;
    step(); rst = 1'b0; #1;
    n = 0;
    for (int i = 0; i < 10; i++) begin
      if (mem_req) n++;
      step(); #1;
    end
    check("stall reqs", 32'(n), 32'd4);
    check("stall count", 32'(count), 32'd4);
    check("stall req", 32'(mem_req), 32'd0);
    ready = 1'b1; #1;
    exp = RPC;
    for (int i = 0; i < 12; i++) begin
      if (valid) begin
        check("drain pc", insn_pc, exp);
        check("drain insn", insn, exp ^ DKEY);
        exp = exp + 32'd4;
      end
      step(); #1;
    end
    check("drain total", exp, RPC + 32'd48);

    // Redirect with 3 buffered + 1 in flight, coincident with a pop.
    rst = 1'b1; ready = 1'b0;
    step(); rst = 1'b0; #1;
    for (int i = 0; i < 4; i++) begin
      step(); #1;
    end
    check("pre-redir count", 32'(count), 32'd3);
    redirect_valid = 1'b1; redirect_pc = 32'h80020103; ready = 1'b1; #1;
    check("redir req", 32'(mem_req), 32'd0);
    check("redir head valid", 32'(valid), 32'd1);
    step(); redirect_valid = 1'b0; #1;
    check("post-redir valid", 32'(valid), 32'd0);
    check("post-redir count", 32'(count), 32'd0);
    check("post-redir req", 32'(mem_req), 32'd1);
    check("post-redir addr", mem_addr, 32'h80020100);
    step(); #1;
    check("redir t+2 valid", 32'(valid), 32'd0);
    step(); #1;
    check("redir t+3 valid", 32'(valid), 32'd1);
    check("redir t+3 pc", insn_pc, 32'h80020100);
    check("redir t+3 insn", insn, 32'h80020100 ^ DKEY);

    // SREC load hold mid-run.
    srec_parse = 1'b1; #1;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      if (mem_req) n++;
      step(); #1;
    end
    check("srec reqs", 32'(n), 32'd0);
    check("srec count", 32'(count), 32'd0);
    check("srec valid", 32'(valid), 32'd0);
    srec_parse = 1'b0; #1;
    got = 0;
    for (int i = 0; i < 5; i++) begin
      if (mem_req) begin
        got = 1;
        break;
      end
      step(); #1;
    end
    check("srec restart req", 32'(got), 32'd1);
    check("srec restart addr", mem_addr, RPC);
    step(); #1;
    step(); #1;
    check("srec restart valid", 32'(valid), 32'd1);
    check("srec restart pc", insn_pc, RPC);

    // Asynchronous reset pulse between edges with 2 entries buffered.
    rst = 1'b1; ready = 1'b0;
    step(); rst = 1'b0; #1;
    for (int i = 0; i < 3; i++) begin
      step(); #1;
    end
    check("pre-rst count", 32'(count), 32'd2);
    #2; rst = 1'b1; #1;
    check_reset_outputs("async");
    #1; rst = 1'b0; ready = 1'b1; #1;
    got = 0;
    for (int i = 0; i < 6; i++) begin
      if (valid) begin
        got = 1;
        break;
      end
      step(); #1;
    end
    check("post-rst valid", 32'(got), 32'd1);
    check("post-rst pc", insn_pc, RPC);
    check("post-rst insn", insn, RPC ^ DKEY);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
